// File: rtl/bsg_vcache_dma_arbiter_pkg.sv
// ============================================================================
// Module   : bsg_vcache_dma_arbiter_pkg
// Brief    : Shared helpers for the multi-cache DMA arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_vcache_dma_arbiter_pkg;

    // Direction encoding carried in the packet MSB (write_not_read).
    typedef enum logic {
        e_dma_read  = 1'b0,
        e_dma_write = 1'b1
    } dma_op_e;

    // Packet layout is {write_not_read, mask, addr}.
    function automatic int dma_pkt_width(input int addr_width, input int mask_width);
        return 1 + mask_width + addr_width;
    endfunction

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_vcache_dma_burst_steer.sv
// ============================================================================
// Module   : bsg_vcache_dma_burst_steer
// Brief    : Tag FIFO plus beat counter; presents the head requester id and
//            retires the entry on the last beat of its burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_vcache_dma_burst_steer
    import bsg_vcache_dma_arbiter_pkg::*;
#(
    parameter int id_width_p  = 1,
    parameter int depth_p     = 4,
    parameter int burst_len_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_v_i,
    input  logic [id_width_p-1:0] push_id_i,
    input  logic                  beat_i,
    output logic                  full_o,
    output logic                  head_v_o,
    output logic [id_width_p-1:0] head_id_o
);

    localparam int c_ptr_w   = safe_clog2(depth_p);
    localparam int c_count_w = $clog2(depth_p + 1);
    localparam int c_beat_w  = safe_clog2(burst_len_p);
    localparam logic [c_ptr_w-1:0]   c_ptr_last  = c_ptr_w'(depth_p - 1);
    localparam logic [c_count_w-1:0] c_depth     = c_count_w'(depth_p);
    localparam logic [c_beat_w-1:0]  c_beat_last = c_beat_w'(burst_len_p - 1);

    logic [id_width_p-1:0] r_mem [depth_p];
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [c_count_w-1:0]  r_count;
    logic [c_beat_w-1:0]   r_beat;

    logic w_push;
    logic w_beat;
    logic w_pop;

    assign full_o    = (r_count == c_depth);
    assign head_v_o  = (r_count != '0);
    assign head_id_o = r_mem[r_rptr];

    // Full wins over a same-cycle pop: no bypass into a full FIFO.
    assign w_push = push_v_i & ~full_o;
    assign w_beat = beat_i & head_v_o;
    assign w_pop  = w_beat & (r_beat == c_beat_last);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_beat  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_count_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_count_w'(1);
            end
            if (w_beat) begin
                r_beat <= w_pop ? '0 : r_beat + c_beat_w'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_vcache_dma_arbiter.sv
// ============================================================================
// Module   : bsg_vcache_dma_arbiter
// Brief    : Round-robin share of one cache DMA port among several vcaches,
//            steering fill / write-back bursts by recorded requester order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_vcache_dma_arbiter
    import bsg_vcache_dma_arbiter_pkg::*;
#(
    parameter int num_caches_p      = 2,
    parameter int dma_addr_width_p  = 28,
    parameter int dma_mask_width_p  = 8,
    parameter int dma_data_width_p  = 32,
    parameter int dma_burst_len_p   = 8,
    parameter int max_outstanding_p = 4,
    parameter int dma_pkt_width_lp  = dma_pkt_width(dma_addr_width_p, dma_mask_width_p)
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,

    input  logic [num_caches_p-1:0][dma_pkt_width_lp-1:0]     cache_dma_pkt_i,
    input  logic [num_caches_p-1:0]                           cache_dma_pkt_v_i,
    output logic [num_caches_p-1:0]                           cache_dma_pkt_yumi_o,

    output logic [num_caches_p-1:0][dma_data_width_p-1:0]     cache_dma_data_o,
    output logic [num_caches_p-1:0]                           cache_dma_data_v_o,
    input  logic [num_caches_p-1:0]                           cache_dma_data_ready_and_i,

    input  logic [num_caches_p-1:0][dma_data_width_p-1:0]     cache_dma_data_i,
    input  logic [num_caches_p-1:0]                           cache_dma_data_v_i,
    output logic [num_caches_p-1:0]                           cache_dma_data_yumi_o,

    output logic [dma_pkt_width_lp-1:0]                       dma_pkt_o,
    output logic                                              dma_pkt_v_o,
    input  logic                                              dma_pkt_yumi_i,

    input  logic [dma_data_width_p-1:0]                       dma_data_i,
    input  logic                                              dma_data_v_i,
    output logic                                              dma_data_ready_and_o,

    output logic [dma_data_width_p-1:0]                       dma_data_o,
    output logic                                              dma_data_v_o,
    input  logic                                              dma_data_yumi_i
);

    localparam int c_id_w = safe_clog2(num_caches_p);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(num_caches_p - 1);
    localparam logic [num_caches_p-1:0] c_one = num_caches_p'(1);

    logic [c_id_w-1:0]       r_ptr;
    logic                    r_locked;
    logic [c_id_w-1:0]       r_lock_id;

    logic [num_caches_p-1:0] w_elig;
    logic                    w_rr_found;
    logic [c_id_w-1:0]       w_rr_id;
    logic [c_id_w-1:0]       w_grant;
    logic                    w_accept;
    logic                    w_is_write;

    logic                    w_rd_full, w_rd_v, w_wr_full, w_wr_v;
    logic [c_id_w-1:0]       w_rd_id, w_wr_id;

    for (genvar i = 0; i < num_caches_p; i++) begin : g_elig
        assign w_elig[i] = cache_dma_pkt_v_i[i] & ~reset_i
            & ~((cache_dma_pkt_i[i][dma_pkt_width_lp-1] == e_dma_write) ? w_wr_full : w_rd_full);
    end

    // First eligible requester at or after the pointer.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = '0;
        for (int k = 0; k < num_caches_p; k++) begin
            if (!w_rr_found && w_elig[(int'(r_ptr) + k) % num_caches_p]) begin
                w_rr_found = 1'b1;
                w_rr_id    = c_id_w'((int'(r_ptr) + k) % num_caches_p);
            end
        end
    end

    assign w_grant     = r_locked ? r_lock_id : w_rr_id;
    assign dma_pkt_o   = cache_dma_pkt_i[w_grant];
    assign dma_pkt_v_o = ~reset_i & (r_locked | w_rr_found);
    assign w_accept    = dma_pkt_v_o & dma_pkt_yumi_i;
    assign w_is_write  = (dma_pkt_o[dma_pkt_width_lp-1] == e_dma_write);

    assign cache_dma_pkt_yumi_o = w_accept ? (c_one << w_grant) : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr     <= '0;
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_accept) begin
            r_locked <= 1'b0;
            r_ptr    <= (w_grant == c_last_id) ? '0 : w_grant + c_id_w'(1);
        end else if (dma_pkt_v_o) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_grant;
        end
    end

    bsg_vcache_dma_burst_steer #(
        .id_width_p  (c_id_w),
        .depth_p     (max_outstanding_p),
        .burst_len_p (dma_burst_len_p)
    ) u_rd_steer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_v_i  (w_accept & ~w_is_write),
        .push_id_i (w_grant),
        .beat_i    (dma_data_v_i & dma_data_ready_and_o),
        .full_o    (w_rd_full),
        .head_v_o  (w_rd_v),
        .head_id_o (w_rd_id)
    );

    bsg_vcache_dma_burst_steer #(
        .id_width_p  (c_id_w),
        .depth_p     (max_outstanding_p),
        .burst_len_p (dma_burst_len_p)
    ) u_wr_steer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_v_i  (w_accept & w_is_write),
        .push_id_i (w_grant),
        .beat_i    (w_wr_v & dma_data_yumi_i),
        .full_o    (w_wr_full),
        .head_v_o  (w_wr_v),
        .head_id_o (w_wr_id)
    );

    for (genvar i = 0; i < num_caches_p; i++) begin : g_fill_bcast
        assign cache_dma_data_o[i] = dma_data_i;
    end

    assign cache_dma_data_v_o   = w_rd_v ? ({{(num_caches_p-1){1'b0}}, dma_data_v_i} << w_rd_id) : '0;
    assign dma_data_ready_and_o = w_rd_v & cache_dma_data_ready_and_i[w_rd_id];

    assign dma_data_o            = cache_dma_data_i[w_wr_id];
    assign dma_data_v_o          = w_wr_v & cache_dma_data_v_i[w_wr_id];
    assign cache_dma_data_yumi_o = w_wr_v ? ({{(num_caches_p-1){1'b0}}, dma_data_yumi_i} << w_wr_id) : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(dma_data_v_i && !w_rd_v))
                else $error("bsg_vcache_dma_arbiter: fill beat with no outstanding read");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_vcache_dma_arbiter.sv
// ============================================================================
// Module   : tb_bsg_vcache_dma_arbiter
// Brief    : Directed self-checking bench for the two-cache DMA arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_vcache_dma_arbiter;

    localparam int c_n   = 2;
    localparam int c_pw  = 37;
    localparam int c_dw  = 32;

    logic                      clk;
    logic                      rst;
    logic [c_n-1:0][c_pw-1:0]  cpkt;
    logic [c_n-1:0]            cpkt_v;
    logic [c_n-1:0]            cpkt_yumi;
    logic [c_n-1:0][c_dw-1:0]  cdata_o;
    logic [c_n-1:0]            cdata_v_o;
    logic [c_n-1:0]            cready;
    logic [c_n-1:0][c_dw-1:0]  cdata_i;
    logic [c_n-1:0]            cdata_v_i;
    logic [c_n-1:0]            cdata_yumi;
    logic [c_pw-1:0]           pkt_o;
    logic                      pkt_v;
    logic                      pkt_yumi;
    logic [c_dw-1:0]           ddata_i;
    logic                      ddata_v_i;
    logic                      dready;
    logic [c_dw-1:0]           ddata_o;
    logic                      ddata_v_o;
    logic                      ddata_yumi;

    int checks = 0;
    int errors = 0;

    bsg_vcache_dma_arbiter u_dut (
        .clk_i                      (clk),
        .reset_i                    (rst),
        .cache_dma_pkt_i            (cpkt),
        .cache_dma_pkt_v_i          (cpkt_v),
        .cache_dma_pkt_yumi_o       (cpkt_yumi),
        .cache_dma_data_o           (cdata_o),
        .cache_dma_data_v_o         (cdata_v_o),
        .cache_dma_data_ready_and_i (cready),
        .cache_dma_data_i           (cdata_i),
        .cache_dma_data_v_i         (cdata_v_i),
        .cache_dma_data_yumi_o      (cdata_yumi),
        .dma_pkt_o                  (pkt_o),
        .dma_pkt_v_o                (pkt_v),
        .dma_pkt_yumi_i             (pkt_yumi),
        .dma_data_i                 (ddata_i),
        .dma_data_v_i               (ddata_v_i),
        .dma_data_ready_and_o       (dready),
        .dma_data_o                 (ddata_o),
        .dma_data_v_o               (ddata_v_o),
        .dma_data_yumi_i            (ddata_yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    function automatic logic [c_pw-1:0] mk(input logic wnr, input logic [27:0] addr);
        return {wnr, 8'hFF, addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic idle();
        cpkt_v     = '0;
        pkt_yumi   = 1'b0;
        ddata_v_i  = 1'b0;
        ddata_i    = '0;
        cdata_v_i  = '0;
        cdata_i    = '0;
        ddata_yumi = 1'b0;
        cready     = 2'b11;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] e;
        idle();
        cpkt[0] = mk(1'b0, 28'h100);
        cpkt[1] = mk(1'b0, 28'h200);

        // Reset state: requests and yumi present while in reset.
        rst      = 1'b1;
        cpkt_v   = 2'b11;
        pkt_yumi = 1'b1;
        step();
        step();
        #1;
        chk("rst_pkt_v", 64'(pkt_v), 64'd0);
        chk("rst_pkt_yumi", 64'(cpkt_yumi), 64'd0);
        chk("rst_cdata_v", 64'(cdata_v_o), 64'd0);
        rst = 1'b0;
        idle();
        #1;
        chk("rst_dready", 64'(dready), 64'd0);
        chk("rst_ddata_v", 64'(ddata_v_o), 64'd0);
        chk("rst_cdata_yumi", 64'(cdata_yumi), 64'd0);

        // Single read from cache 1.
        cpkt_v = 2'b10;
        #1;
        chk("sr_pkt_v", 64'(pkt_v), 64'd1);
        chk("sr_pkt", 64'(pkt_o), 64'(mk(1'b0, 28'h200)));
        pkt_yumi = 1'b1;
        #1;
        chk("sr_yumi", 64'(cpkt_yumi), 64'b10);
        step();
        idle();
        ddata_v_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ddata_i = 32'h10 + 32'(k);
            #1;
            chk("sr_fill_v", 64'(cdata_v_o), 64'b10);
            chk("sr_fill_data", 64'(cdata_o[1]), 64'h10 + 64'(k));
            chk("sr_dready", 64'(dready), 64'd1);
            step();
        end
        ddata_v_i = 1'b0;
        #1;
        chk("sr_fifo_empty", 64'(dready), 64'd0);

        // Contention: grants alternate starting at cache 0.
        do_reset();
        cpkt_v   = 2'b11;
        pkt_yumi = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("ct_grant", 64'(cpkt_yumi), 64'(e));
            chk("ct_pkt", 64'(pkt_o), (k % 2 == 0) ? 64'(mk(1'b0, 28'h100)) : 64'(mk(1'b0, 28'h200)));
            step();
        end
        idle();
        ddata_v_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            e = (b % 2 == 0) ? 2'b01 : 2'b10;
            for (int k = 0; k < 8; k++) begin
                ddata_i = 32'(b * 16 + k);
                #1;
                chk("ct_route", 64'(cdata_v_o), 64'(e));
                step();
            end
        end
        ddata_v_i = 1'b0;
        #1;
        chk("ct_drained", 64'(dready), 64'd0);

        // Interleaved: cache 1 read, cache 0 write-back, concurrent beats.
        do_reset();
        cpkt[1]  = mk(1'b0, 28'h300);
        cpkt_v   = 2'b10;
        pkt_yumi = 1'b1;
        #1;
        chk("il_rd_yumi", 64'(cpkt_yumi), 64'b10);
        step();
        cpkt[0]    = mk(1'b1, 28'h400);
        cpkt_v     = 2'b01;
        cdata_v_i  = 2'b11;
        cdata_i[0] = 32'hA0;
        cdata_i[1] = 32'hBB;
        #1;
        chk("il_wr_yumi", 64'(cpkt_yumi), 64'b01);
        chk("il_wb_not_early", 64'(ddata_v_o), 64'd0);
        step();
        cpkt_v     = '0;
        pkt_yumi   = 1'b0;
        ddata_yumi = 1'b1;
        ddata_v_i  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cdata_i[0] = 32'hA0 + 32'(k);
            ddata_i    = 32'h30 + 32'(k);
            #1;
            chk("il_wb_data", 64'(ddata_o), 64'hA0 + 64'(k));
            chk("il_wb_v", 64'(ddata_v_o), 64'd1);
            chk("il_wb_yumi", 64'(cdata_yumi), 64'b01);
            chk("il_fill_v", 64'(cdata_v_o), 64'b10);
            chk("il_fill_data", 64'(cdata_o[1]), 64'h30 + 64'(k));
            step();
        end
        idle();
        #1;
        chk("il_wb_done", 64'(ddata_v_o), 64'd0);
        chk("il_rd_done", 64'(dready), 64'd0);

        // Backpressure with pointer at 1: lock must hold cache 0.
        cpkt[0] = mk(1'b0, 28'h500);
        cpkt[1] = mk(1'b0, 28'h600);
        cpkt_v  = 2'b01;
        #1;
        chk("bp_first", 64'(pkt_o), 64'(mk(1'b0, 28'h500)));
        step();
        cpkt_v = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_hold_pkt", 64'(pkt_o), 64'(mk(1'b0, 28'h500)));
            chk("bp_no_yumi", 64'(cpkt_yumi), 64'd0);
            step();
        end
        pkt_yumi = 1'b1;
        #1;
        chk("bp_yumi", 64'(cpkt_yumi), 64'b01);
        step();
        cpkt_v = 2'b10;
        #1;
        chk("bp_next", 64'(pkt_o), 64'(mk(1'b0, 28'h600)));
        chk("bp_next_yumi", 64'(cpkt_yumi), 64'b10);
        step();

        // FIFO full: four reads outstanding block a fifth, not a write.
        do_reset();
        cpkt[0]  = mk(1'b0, 28'h700);
        cpkt_v   = 2'b01;
        pkt_yumi = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ff_fill", 64'(cpkt_yumi), 64'b01);
            step();
        end
        cpkt[1] = mk(1'b1, 28'h800);
        cpkt_v  = 2'b11;
        #1;
        chk("ff_write_ok", 64'(cpkt_yumi), 64'b10);
        chk("ff_write_pkt", 64'(pkt_o), 64'(mk(1'b1, 28'h800)));
        step();
        cpkt_v   = 2'b01;
        pkt_yumi = 1'b0;
        #1;
        chk("ff_blocked", 64'(pkt_v), 64'd0);
        ddata_v_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ddata_i = 32'hC0 + 32'(k);
            #1;
            chk("ff_route", 64'(cdata_v_o), 64'b01);
            chk("ff_no_bypass", 64'(pkt_v), 64'd0);
            step();
        end
        ddata_v_i = 1'b0;
        pkt_yumi  = 1'b1;
        #1;
        chk("ff_fifth", 64'(cpkt_yumi), 64'b01);
        step();

        // Mid-burst reset, then a fresh read.
        do_reset();
        cpkt[1]  = mk(1'b0, 28'h900);
        cpkt_v   = 2'b10;
        pkt_yumi = 1'b1;
        step();
        idle();
        ddata_v_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ddata_i = 32'h40 + 32'(k);
            #1;
            chk("mr_pre_v", 64'(cdata_v_o), 64'b10);
            step();
        end
        ddata_i = 32'h43;
        rst     = 1'b1;
        step();
        rst       = 1'b0;
        ddata_v_i = 1'b0;
        #1;
        chk("mr_dready", 64'(dready), 64'd0);
        chk("mr_cdata_v", 64'(cdata_v_o), 64'd0);
        chk("mr_pkt_v", 64'(pkt_v), 64'd0);
        chk("mr_ddata_v", 64'(ddata_v_o), 64'd0);
        cpkt_v   = 2'b10;
        pkt_yumi = 1'b1;
        #1;
        chk("mr_new_yumi", 64'(cpkt_yumi), 64'b10);
        step();
        idle();
        ddata_v_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ddata_i = 32'h50 + 32'(k);
            #1;
            chk("mr_fill_v", 64'(cdata_v_o), 64'b10);
            chk("mr_fill_data", 64'(cdata_o[1]), 64'h50 + 64'(k));
            step();
        end
        ddata_v_i = 1'b0;
        #1;
        chk("mr_done", 64'(dready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsg_vcache_dma_arbiter.md
Name: bsg_vcache_dma_arbiter

Overview:
- Shares one bsg_cache DMA port among num_caches_p vcaches, for example the north and south vcache of a column pair.
- The shared port feeds a single bsg_cache_dma_to_wormhole adapter, so only one wormhole endpoint is needed per pair.
- Arbitrates DMA packets round-robin.
- Records the requester of each accepted packet in order, then steers read-fill beats back to that requester and pulls write-back beats from it.
- Sits between the bsg_cache DMA ports and the DMA-to-wormhole adapter inside a multi-cache vcache tile.

Parameters:
- num_caches_p, 2: number of cache DMA requesters (2..8).
- dma_addr_width_p, 28: cache DMA address width.
- dma_mask_width_p, 8: cache block size in words; also the DMA packet mask width.
- dma_data_width_p, 32: DMA data beat width.
- dma_burst_len_p, 8: data beats per block (block bits / dma_data_width_p), at least 1.
- max_outstanding_p, 4: depth of the read and write tag FIFOs.
- dma_pkt_width_lp (derived): `bsg_cache_dma_pkt_width(dma_addr_width_p, dma_mask_width_p). Bit MSB is write_not_read.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- cache_dma_pkt_i  in  [num_caches_p][dma_pkt_width_lp]  DMA packet from each cache.
- cache_dma_pkt_v_i  in  num_caches_p  packet valid.
- cache_dma_pkt_yumi_o  out  num_caches_p  packet consumed.
- cache_dma_data_o  out  [num_caches_p][dma_data_width_p]  read-fill data to each cache (broadcast).
- cache_dma_data_v_o  out  num_caches_p  fill beat valid.
- cache_dma_data_ready_and_i  in  num_caches_p  cache ready for a fill beat.
- cache_dma_data_i  in  [num_caches_p][dma_data_width_p]  write-back data from each cache.
- cache_dma_data_v_i  in  num_caches_p  write-back beat valid.
- cache_dma_data_yumi_o  out  num_caches_p  write-back beat consumed.
- dma_pkt_o  out  dma_pkt_width_lp  packet to the adapter.
- dma_pkt_v_o  out  1  packet valid.
- dma_pkt_yumi_i  in  1  adapter consumed the packet.
- dma_data_i  in  dma_data_width_p  fill data from the adapter.
- dma_data_v_i  in  1  fill beat valid.
- dma_data_ready_and_o  out  1  arbiter ready for a fill beat.
- dma_data_o  out  dma_data_width_p  write-back data to the adapter.
- dma_data_v_o  out  1  write-back beat valid.
- dma_data_yumi_i  in  1  adapter consumed the write-back beat.

Behaviour:
- Reset: all v, yumi and ready outputs are 0. Round-robin pointer = 0. Both tag FIFOs are empty. Both beat counters = 0.
- Eligibility: requester i is eligible when cache_dma_pkt_v_i[i] is set and its tag FIFO (read or write, chosen by write_not_read) is not full.
- Grant: a round-robin grant among eligible requesters, combinational from the current pointer.
  - dma_pkt_o = packet of the granted requester; dma_pkt_v_o = any eligible.
- Lock: once dma_pkt_v_o is asserted, a lock register holds the grant until dma_pkt_yumi_i. This keeps the packet stable and prevents the grant from switching.
- Packet acceptance, on dma_pkt_yumi_i:
  - cache_dma_pkt_yumi_o[grant] = 1 in the same cycle.
  - The grant id is pushed to the read-tag FIFO or write-tag FIFO according to write_not_read.
  - The pointer advances to grant+1, mod num_caches_p.
- Read path:
  - When the read FIFO is non-empty, head id h is used; cache_dma_data_v_o[h] = dma_data_v_i and dma_data_ready_and_o = cache_dma_data_ready_and_i[h].
  - cache_dma_data_o is broadcast as dma_data_i.
  - The read counter increments on each v&ready beat. On beat dma_burst_len_p-1 the counter wraps to 0 and the FIFO pops.
  - When the read FIFO is empty, dma_data_ready_and_o = 0 and all cache_dma_data_v_o = 0. A beat arriving in this state is a protocol error and is flagged by a simulation assertion.
- Write path:
  - When the write FIFO is non-empty, head id h is used; dma_data_o = cache_dma_data_i[h], dma_data_v_o = cache_dma_data_v_i[h], and cache_dma_data_yumi_o[h] = dma_data_yumi_i.
  - The write counter increments per yumi and pops the FIFO at the last beat.
  - Write data may start the cycle after the packet yumi, never before it.
- Concurrency: the read and write paths run concurrently and independently of packet arbitration. Pushes and pops on the same FIFO in one cycle are legal.
- FIFO full: a full FIFO blocks eligibility even if a pop occurs in that cycle. No bypass.
- Latency: zero added cycles on data paths. Packet output is combinational from inputs plus lock state.
- Reset mid-operation: all in-flight bookkeeping is discarded. Caches and adapter are reset by the same reset_i.

Decomposition:
- Package: DMA packet struct and width macros reuse bsg_cache_pkg (`declare_bsg_cache_dma_pkt_s). No new package.
- Primitives used: bsg_arb_round_robin (or equivalent with lock), and two bsg_fifo_1r1w_small instances of width clog2(num_caches_p) and depth max_outstanding_p.
- Sub-module: bsg_vcache_dma_burst_steer, instantiated twice. It pairs a tag FIFO with a beat counter, outputs the head id and a valid, and pops at the last beat.

Test Plan:
- Single read: cache 1 issues a read, adapter returns 8 beats 0x10..0x17. Expected: cache 1 receives exactly those 8 beats; cache 0 sees v=0; read FIFO is empty afterwards.
- Contention: caches 0 and 1 both post reads continuously and the adapter yumis every cycle. Expected: grants alternate 0,1,0,1, starting at 0 after reset; returned bursts are routed in the same order.
- Interleaved traffic: cache 0 write-back with data 0xA0..0xA7 concurrent with a cache 1 read fill. Expected: adapter dma_data_o carries 0xA*; cache 1 receives all fill beats; no cross-routing.
- Backpressure: adapter holds dma_pkt_yumi_i low for 5 cycles while cache 1 becomes valid. Expected: dma_pkt_o stays cache 0's packet, unchanged until yumi.
- FIFO full: 4 reads are accepted with no data returned, then a 5th read and a write are presented. Expected: read not yumi'd; write accepted. After the first read burst completes, the 5th read is accepted.
- Mid-burst reset: reset asserted during beat 3 of a fill. Expected: next cycle all outputs are 0; a fresh read completes normally.
